// File: rtl/hazard_stall_controller_if.sv
// rtl/hazard_stall_controller_if.sv - pipeline-side signal bundle of the hazard stall controller
//
// Groups the pipeline-register observations fed to the controller and the
// enables/flush/freeze it drives back. clk and rst_n stay outside the bundle.
//   master : pipeline side (drives hazard inputs, receives control outputs)
//   slave  : controller side
interface hazard_stall_controller_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  ID_EXE_MemRead;
    logic [REG_ADDR_W-1:0] ID_EXE_rd;
    logic [REG_ADDR_W-1:0] IF_ID_rs1;
    logic [REG_ADDR_W-1:0] IF_ID_rs2;
    logic                  IF_ID_uses_rs1;
    logic                  IF_ID_uses_rs2;
    logic                  EXE_MEM_MemAccess;
    logic                  dmem_ready;
    logic                  branch_taken;
    logic                  control_MUX_select;
    logic                  IF_ID_REG_Write;
    logic                  PC_Write;
    logic                  IF_ID_flush;
    logic                  pipe_freeze;
    logic [CNT_W-1:0]      stall_cycles;

    modport master (
        output ID_EXE_MemRead, ID_EXE_rd, IF_ID_rs1, IF_ID_rs2,
               IF_ID_uses_rs1, IF_ID_uses_rs2, EXE_MEM_MemAccess,
               dmem_ready, branch_taken,
        input  control_MUX_select, IF_ID_REG_Write, PC_Write,
               IF_ID_flush, pipe_freeze, stall_cycles
    );

    modport slave (
        input  ID_EXE_MemRead, ID_EXE_rd, IF_ID_rs1, IF_ID_rs2,
               IF_ID_uses_rs1, IF_ID_uses_rs2, EXE_MEM_MemAccess,
               dmem_ready, branch_taken,
        output control_MUX_select, IF_ID_REG_Write, PC_Write,
               IF_ID_flush, pipe_freeze, stall_cycles
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - load-use / memory-wait / branch-flush hazard controller
//
// Detects load-use hazards between ID/EX and IF/ID and inserts
// LOAD_STALL_CYCLES bubbles (1..15) per hazard, freezes the whole pipe while
// a data-memory access is outstanding, and flushes IF/ID on taken branches.
// Priority: freeze > flush > load stall > idle. Outputs are combinational
// from state and inputs, so they act in the detection cycle.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of hazard_stall_controller_if (hazard inputs in;
//           control_MUX_select, IF_ID_REG_Write, PC_Write, IF_ID_flush,
//           pipe_freeze and the saturating stall_cycles counter out)
module hazard_stall_controller #(
    parameter int REG_ADDR_W        = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    hazard_stall_controller_if.slave  bus
);

    typedef enum logic {
        IDLE,
        LOAD_STALL
    } state_t;

    // Bubbles still owed after the one issued on entry.
    localparam logic [3:0]       RELOAD  = 4'(LOAD_STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_next;
    logic [3:0]       remain;
    logic [3:0]       remain_next;
    logic [CNT_W-1:0] stall_cnt;

    logic hazard;
    logic freeze;
    logic mux_sel;
    logic ifid_we;
    logic pc_we;
    logic flush;
    logic freeze_out;

    // x0 is hardwired zero, so a load targeting it can never create a hazard.
    always_comb begin
        hazard = bus.ID_EXE_MemRead
               && (bus.ID_EXE_rd != '0)
               && ((bus.IF_ID_uses_rs1 && (bus.IF_ID_rs1 == bus.ID_EXE_rd))
                || (bus.IF_ID_uses_rs2 && (bus.IF_ID_rs2 == bus.ID_EXE_rd)));
        freeze = bus.EXE_MEM_MemAccess && !bus.dmem_ready;
    end

    always_comb begin
        state_next  = state;
        remain_next = remain;
        mux_sel     = 1'b0;
        ifid_we     = 1'b1;
        pc_we       = 1'b1;
        flush       = 1'b0;
        freeze_out  = 1'b0;

        if (!rst_n) begin
            // idle outputs while held in reset
        end else if (freeze) begin
            // whole pipe holds; the pending stall resumes once memory is ready
            freeze_out = 1'b1;
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
        end else if (bus.branch_taken) begin
            // the stalled instruction is wrong-path, so the stall is dropped
            flush       = 1'b1;
            mux_sel     = 1'b1;
            state_next  = IDLE;
            remain_next = '0;
        end else if (state == LOAD_STALL) begin
            mux_sel = 1'b1;
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            if (remain == 4'd1) begin
                state_next  = IDLE;
                remain_next = '0;
            end else begin
                remain_next = remain - 4'd1;
            end
        end else if (hazard) begin
            mux_sel = 1'b1;
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            if (RELOAD != 4'd0) begin
                state_next  = LOAD_STALL;
                remain_next = RELOAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            remain    <= '0;
            stall_cnt <= '0;
        end else begin
            state  <= state_next;
            remain <= remain_next;
            if (!pc_we && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.control_MUX_select = mux_sel;
    assign bus.IF_ID_REG_Write    = ifid_we;
    assign bus.PC_Write           = pc_we;
    assign bus.IF_ID_flush        = flush;
    assign bus.pipe_freeze        = freeze_out;
    assign bus.stall_cycles       = stall_cnt;

endmodule
